// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the keypad matrix scanner.
// Holds the scanner state encoding, a width helper for codes and counters,
// and the row/column to key-index mapping.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DB_PRESS,
    PRESSED
  } kp_state_e;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Key index reported downstream: row-major over the matrix.
  function automatic int unsigned code_of(input int unsigned row_idx,
                                          input int unsigned col_idx,
                                          input int unsigned cols);
    return row_idx * cols + col_idx;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// keypad_matrix_scanner_if: key event channel between the scanner (master)
// and the consumer (slave). One key index per event, valid/ack handshake.
interface keypad_matrix_scanner_if #(
  parameter int CW = 4
);
  logic [CW-1:0] key_code;
  logic          key_valid;
  logic          key_ack;
  logic          key_down;
  logic          key_ovf;

  modport master (output key_code, key_valid, key_down, key_ovf, input key_ack);
  modport slave  (input key_code, key_valid, key_down, key_ovf, output key_ack);
endinterface

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: free-running divider that strobes tick for one cycle
// every SCAN_DIV clocks; the scanner only samples and advances on ticks.
module keypad_tick_gen
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic key_clk,
  input  logic rst,
  output logic tick
);
  localparam int DW = width_of(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_reg;

  // Count 0..SCAN_DIV-1 and wrap.
  always_ff @(posedge key_clk) begin
    if (rst) begin
      div_reg <= '0;
    end else if (div_reg == DIV_LAST) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DW'(1);
    end
  end

  assign tick = (div_reg == DIV_LAST);
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: ROWS x COLS matrix keypad scanner. Drives one-hot
// column strobes, debounces press and release, and reports one key index per
// event over a valid/ack channel with overrun flagging.
// Optional auto-repeat is built only when KEYPAD_REPEAT_EN is defined.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE     = 3,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16
) (
  input  logic                 key_clk,
  input  logic                 rst,
  input  logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      col,
  keypad_matrix_scanner_if.master kif
);
  localparam int CW = width_of(ROWS * COLS);
  localparam int IW = width_of(COLS);
  localparam int RW = width_of(ROWS);
  localparam int NW = width_of(DEBOUNCE);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(COLS - 1);
  localparam logic [NW-1:0]   CNT_LAST  = NW'(DEBOUNCE - 1);
  localparam logic [COLS-1:0] COL_FIRST = COLS'(1);

  logic            tick;
  kp_state_e       state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [COLS-1:0] col_reg, col_next;
  logic [ROWS-1:0] pat_reg, pat_next;
  logic [RW-1:0]   row_idx_reg, row_idx_next;
  logic [NW-1:0]   cnt_reg, cnt_next;
  logic            key_down_reg, key_down_next;
  logic [RW-1:0]   row_enc;
  logic            single_bit;
  logic            enter_pressed;
  logic            rpt_fire;
  logic            emit;
  logic            load;
  logic [CW-1:0]   code_next;
  logic [CW-1:0]   key_code_reg;
  logic            key_valid_reg;
  logic            key_ovf_reg;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .key_clk (key_clk),
    .rst     (rst),
    .tick    (tick)
  );

  // Row index of the (single) asserted row bit.
  always_comb begin
    row_enc = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row[i]) row_enc = RW'(i);
    end
  end

  // Two or more row bits on one column means ghosting and is never accepted.
  assign single_bit = ($countones(row) == 1);

  // Scanner state, strobe, latched key and shared debounce counter.
  always_ff @(posedge key_clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      col_reg      <= '1;
      pat_reg      <= '0;
      row_idx_reg  <= '0;
      cnt_reg      <= '0;
      key_down_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      col_reg      <= col_next;
      pat_reg      <= pat_next;
      row_idx_reg  <= row_idx_next;
      cnt_reg      <= cnt_next;
      key_down_reg <= key_down_next;
    end
  end

  // Next-state logic; everything advances only on scan ticks.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    col_next      = col_reg;
    pat_next      = pat_reg;
    row_idx_next  = row_idx_reg;
    cnt_next      = cnt_reg;
    key_down_next = key_down_reg;
    enter_pressed = 1'b0;
    if (tick) begin
      case (state_reg)
        IDLE: begin
          if (row != '0) begin
            state_next = SCAN;
            idx_next   = '0;
            col_next   = COL_FIRST;
          end
        end
        SCAN: begin
          if (single_bit) begin
            pat_next     = row;
            row_idx_next = row_enc;
            if (DEBOUNCE == 1) begin
              state_next    = PRESSED;
              cnt_next      = '0;
              key_down_next = 1'b1;
              enter_pressed = 1'b1;
            end else begin
              state_next = DB_PRESS;
              cnt_next   = NW'(1);
            end
          end else if (idx_reg == IDX_LAST) begin
            state_next = IDLE;
            idx_next   = '0;
            col_next   = '1;
          end else begin
            idx_next = idx_reg + IW'(1);
            col_next = col_reg << 1;
          end
        end
        DB_PRESS: begin
          if (row == pat_reg) begin
            if (cnt_reg == CNT_LAST) begin
              state_next    = PRESSED;
              cnt_next      = '0;
              key_down_next = 1'b1;
              enter_pressed = 1'b1;
            end else begin
              cnt_next = cnt_reg + NW'(1);
            end
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
            col_next   = '1;
          end
        end
        PRESSED: begin
          // Any nonzero row counts as still held, even a different pattern.
          if (row == '0) begin
            if (cnt_reg == CNT_LAST) begin
              state_next    = IDLE;
              cnt_next      = '0;
              col_next      = '1;
              key_down_next = 1'b0;
            end else begin
              cnt_next = cnt_reg + NW'(1);
            end
          end else begin
            cnt_next = '0;
          end
        end
        default: begin
          state_next = IDLE;
          col_next   = '1;
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RPW = width_of(REPEAT_DELAY + REPEAT_RATE);
  localparam logic [RPW-1:0] RPT_FIRST = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RPT_NEXT  = RPW'(REPEAT_DELAY + REPEAT_RATE - 1);
  localparam logic [RPW-1:0] RPT_BASE  = RPW'(REPEAT_DELAY);

  logic [RPW-1:0] rpt_cnt_reg;

  // Ticks held since entering PRESSED; parks at REPEAT_DELAY after each repeat.
  always_ff @(posedge key_clk) begin
    if (rst || enter_pressed) begin
      rpt_cnt_reg <= '0;
    end else if (tick && state_reg == PRESSED) begin
      if (row == '0) begin
        rpt_cnt_reg <= '0;
      end else if (rpt_cnt_reg == RPT_NEXT) begin
        rpt_cnt_reg <= RPT_BASE;
      end else begin
        rpt_cnt_reg <= rpt_cnt_reg + RPW'(1);
      end
    end
  end

  assign rpt_fire = tick && (state_reg == PRESSED) && (row != '0) &&
                    ((rpt_cnt_reg == RPT_FIRST) || (rpt_cnt_reg == RPT_NEXT));
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign rpt_fire = 1'b0;
`endif

  assign emit      = enter_pressed | rpt_fire;
  assign load      = emit && (!key_valid_reg || kif.key_ack);
  assign code_next = CW'(code_of(int'(row_idx_next), int'(idx_next), COLS));

  // Event register: load a new code, hold until acknowledged, or flag a drop.
  always_ff @(posedge key_clk) begin
    if (rst) begin
      key_code_reg  <= '0;
      key_valid_reg <= 1'b0;
      key_ovf_reg   <= 1'b0;
    end else begin
      key_ovf_reg <= emit && key_valid_reg && !kif.key_ack;
      if (load) begin
        key_valid_reg <= 1'b1;
        key_code_reg  <= code_next;
      end else if (key_valid_reg && kif.key_ack) begin
        key_valid_reg <= 1'b0;
      end
    end
  end

  assign col           = col_reg;
  assign kif.key_code  = key_code_reg;
  assign kif.key_valid = key_valid_reg;
  assign kif.key_down  = key_down_reg;
  assign kif.key_ovf   = key_ovf_reg;
endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Parametrised ROWS×COLS matrix-keypad scanner: the next generation of our 4×4 keypad driver. It drives one-hot column strobes, samples row returns, debounces press and release, and reports one key index per event through a valid/ack handshake. Optionally it generates auto-repeat events. It sits between the board keypad pins and the game control logic; mapping indices to legends is done downstream.

## Interface
- ROWS, 4: number of row inputs (≥2)
- COLS, 4: number of column outputs (≥2)
- SCAN_DIV, 4: key_clk cycles per scan tick (≥2)
- DEBOUNCE, 3: consecutive matching ticks to accept a press or release (≥1)
- REPEAT_DELAY, 64: ticks held before the first repeat (used only with the repeat macro)
- REPEAT_RATE, 16: ticks between repeats (used only with the repeat macro)
- key_clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- row  in  ROWS  row returns, active-high, pre-synchronised
- col  out  COLS  column strobes; all-ones when idle, one-hot while scanning or held
- key_code  out  CW=$clog2(ROWS*COLS)  row_idx*COLS+col_idx, stable while key_valid
- key_valid  out  1  event pending
- key_ack  in  1  consumer accepts the event
- key_down  out  1  high while in PRESSED
- key_ovf  out  1  one-cycle pulse: an event was dropped because key_valid was still high

## Operation
- Tick: divider counts 0..SCAN_DIV-1; tick = 1 cycle when count==SCAN_DIV-1. Row is sampled and col/state advance only on tick cycles.
- IDLE: col=all ones. At a tick with row!=0: col<=one-hot bit 0, go to SCAN with idx=0.
- SCAN: at a tick, classify row:
  - exactly one bit set: latch row_idx and col_idx=idx, DEBOUNCE count=1. If DEBOUNCE==1 go to PRESSED, else go to DB_PRESS.
  - zero or more than one bit set (ghosting): advance idx. After idx==COLS-1, go to IDLE with col all ones.
- DB_PRESS: col held. At a tick with row equal to the latched pattern: count++, and when count==DEBOUNCE go to PRESSED. Any other row value: go to IDLE.
- PRESSED: emit an event on entry. At a tick with row==0: release count++. At a tick with row!=0: release count cleared; a changed pattern is ignored. When release count==DEBOUNCE: go to IDLE with col all ones.
- Event emission: if key_valid is low, or key_ack is high in the same cycle, load key_code and set key_valid. Otherwise drop the event and pulse key_ovf.
- Handshake: key_valid stays high until a cycle where key_valid&&key_ack; it clears the next cycle unless a simultaneous load occurs. key_ack while key_valid is low is ignored.
- Reset (at any time, including mid-scan): state=IDLE, divider=0, all counters=0, col=all ones, key_code=0, key_valid=0, key_down=0, key_ovf=0.

## Timing
- col changes the cycle after a tick. row is sampled a full SCAN_DIV cycles after the matching col change.
- Press latency, measured from the first tick that sees row!=0 in IDLE: the press is accepted at the tick number (1 + (c+1) + (DEBOUNCE-1)), where c is the column index. key_valid rises on the cycle after that tick.
- key_down rises together with key_valid on entry to PRESSED. It falls the cycle after the DEBOUNCE-th release tick.
- key_ovf is exactly one cycle wide, on the cycle the event would have loaded.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In PRESSED, a repeat counter counts ticks from entry.
  - The first repeat event fires at tick REPEAT_DELAY, then every REPEAT_RATE ticks.
  - Repeat events use the same key_code and handshake/overflow rules.
  - The counter clears on any release tick.
- Macro undefined: exactly one event per accepted press. REPEAT_* parameters are ignored and no repeat logic is built.

## Structure
- keypad_pkg holds:
  - the state enum (IDLE, SCAN, DB_PRESS, PRESSED)
  - a width function for CW and the counters
  - a code function (row_idx, col_idx, COLS) → key_code
- Sub-module keypad_tick_gen: SCAN_DIV divider producing the tick strobe, with synchronous reset.

## Test plan
- Defaults. Hold row=4'b0010 when col=4'b0100 (key at row 1, col 2) → key_code=6. key_valid rises the cycle after the 6th tick counted from detection. col=4'b0100 and key_down=1 while held.
- Release after an accepted press → key_down falls after 3 zero-row ticks and col returns to 4'hF. No extra event.
- Bounce: row toggles 0/nonzero on alternate ticks for 10 ticks → no key_valid and state returns to IDLE. Ghosting: two row bits set on every column → no event.
- Handshake: press key 0 and key 5 sequentially with no key_ack → key_code stays 0 and key_ovf pulses once for key 5. Assert key_ack in the same cycle as the second event → key_code=5 and key_valid stays high.
- Reset asserted mid-DB_PRESS → the next cycle shows col=4'hF, key_valid=0, key_down=0. Re-press → normal latency.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY=8, REPEAT_RATE=4, and key_ack tied high → events at entry, tick 8, 12, and 16 of the hold. Without the macro → one event only.
